// File: rtl/camera_view_stepper.sv
// ----------------------------------------------------------------------------
// camera_view_stepper
//
// Moves the displayed view angle toward the requested camera offset one
// position at a time on a 64-position ring, always taking the shorter way
// round (an exact half-turn goes +1). Every step is announced to the
// renderer with a level req/done handshake, and after each completed step
// the stepper waits a dwell period so the rotation stays visible.
//
// Optional build macro:
//   RENDER_TIMEOUT_EN  - adds a watchdog on the render handshake. If the
//                        renderer does not answer within TIMEOUT cycles the
//                        step is treated as complete and render_err latches
//                        high until reset. Without the macro render_err is 0.
//
// Parameters:
//   STEP_DIV  - dwell cycles after render_done before the next step (>= 1)
//   TIMEOUT   - render watchdog limit in cycles (only with RENDER_TIMEOUT_EN)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   camera_offset  in   [5:0] target view position, modulo 64
//   render_done    in   renderer finished the frame at view_angle
//   view_angle     out  [5:0] current displayed position
//   render_req     out  render request, held until render_done
//   step_dir       out  direction of the last step (1 = +1, 0 = -1)
//   busy           out  high whenever a step or dwell is in progress
//   render_err     out  sticky render timeout flag
// ----------------------------------------------------------------------------
module camera_view_stepper #(
    parameter int STEP_DIV = 4,
    parameter int TIMEOUT  = 1048576
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] camera_offset,
    input  logic       render_done,
    output logic [5:0] view_angle,
    output logic       render_req,
    output logic       step_dir,
    output logic       busy,
    output logic       render_err
);

    // The dwell counter only has to hold STEP_DIV-1.
    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_DIV - 1);

    // Reject parameter values the stepper cannot honour.
    if (STEP_DIV < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("camera_view_stepper: STEP_DIV and TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DIV
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       target_q;
    logic [5:0]       angle_q, angle_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       diff;

    // Wraparound distance from the current angle to the target; values
    // 1..32 mean the forward path is the shorter (or tied) one.
    assign diff = target_q - angle_q;

`ifdef RENDER_TIMEOUT_EN
    localparam logic [19:0] WD_LAST = 20'(TIMEOUT - 1);

    logic [19:0] wd_q, wd_d;
    logic        err_q, err_d;
`endif

    // The target is captured every cycle; all decisions look only at the
    // captured copy so the input path is a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= '0;
        end else begin
            target_q <= camera_offset;
        end
    end

    // Stepper state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            angle_q <= '0;
            dir_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            angle_q <= angle_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef RENDER_TIMEOUT_EN
    // Watchdog and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
`endif

    // Next-state logic. The angle only moves when leaving IDLE, so it is
    // stable for the whole time the renderer is working on it. The
    // direction is re-derived from the latest target at every IDLE visit,
    // which lets a changed target take effect on the very next step.
    always_comb begin
        state_d = state_q;
        angle_d = angle_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
`ifdef RENDER_TIMEOUT_EN
        wd_d    = '0;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (diff != 6'd0) begin
                    state_d = REQ;
                    if (diff <= 6'd32) begin
                        angle_d = angle_q + 6'd1;
                        dir_d   = 1'b1;
                    end else begin
                        angle_d = angle_q - 6'd1;
                        dir_d   = 1'b0;
                    end
                end
            end
            REQ: begin
                if (render_done) begin
                    state_d = WAIT_DIV;
                    cnt_d   = CNT_LOAD;
`ifdef RENDER_TIMEOUT_EN
                end else if (wd_q == WD_LAST) begin
                    // Give up on this frame but keep the stepped angle.
                    state_d = WAIT_DIV;
                    cnt_d   = CNT_LOAD;
                    err_d   = 1'b1;
                end else begin
                    wd_d    = wd_q + 20'd1;
`endif
                end
            end
            WAIT_DIV: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The request is decoded straight from the state flop so it falls
    // together with the asynchronous reset.
    assign view_angle = angle_q;
    assign step_dir   = dir_q;
    assign render_req = (state_q == REQ);
    assign busy       = (state_q != IDLE);
`ifdef RENDER_TIMEOUT_EN
    assign render_err = err_q;
`else
    assign render_err = 1'b0;
`endif

endmodule

// File: doc/camera_view_stepper.md
Name: camera_view_stepper

Overview:
- Consumer side of the camera-offset interface: takes the 6-bit `camera_offset` target from the user-input block and moves a displayed `view_angle` toward it, one step at a time.
- Each step takes the shortest path around the 64-position ring.
- Each step is handed to the renderer with a req/done handshake, and steps are rate-limited so rotation is visible and smooth.
- Sits between camera-offset generation and the frame renderer/projection logic.

Parameters:
- STEP_DIV, 4, minimum clk cycles of dwell after `render_done` before the next step may start (≥1).
- TIMEOUT, 1048576, cycles to wait for `render_done`; used only with `RENDER_TIMEOUT_EN`.

Ports:
- clk  input  1  system clock, all logic posedge.
- rst_n  input  1  asynchronous active-low reset.
- camera_offset  input  6  target view position, 0..63, modulo 64.
- render_done  input  1  renderer finished the frame for the current `view_angle`; single-cycle or level.
- view_angle  output  6  current displayed position (registered).
- render_req  output  1  request render at `view_angle`; level, held until `render_done`.
- step_dir  output  1  direction of the last step: 1 = +1, 0 = −1.
- busy  output  1  high whenever state ≠ IDLE.
- render_err  output  1  sticky timeout flag; constant 0 when `RENDER_TIMEOUT_EN` is undefined.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, view_angle=0, render_req=0, step_dir=1, busy=0, render_err=0, dwell counter=0.
- Target handling: `camera_offset` is registered once (target_q); all decisions use target_q, so there is 1 cycle of input latency.
- Distance: diff = (target_q − view_angle) mod 64, computed as 6-bit unsigned wraparound.
- States: IDLE, REQ, WAIT_DIV.
- IDLE:
  - diff==0 → stay.
  - 1 ≤ diff ≤ 32 → next cycle: view_angle+=1 (wraps 63→0), step_dir=1, render_req=1, go to REQ.
  - diff ≥ 33 → same, but view_angle−=1 (wraps 0→63), step_dir=0.
  - Tie diff==32 always steps +1.
- REQ:
  - render_req held 1 and view_angle stable until render_done=1 is sampled.
  - On that edge: render_req=0, counter loaded with STEP_DIV−1, go to WAIT_DIV.
  - render_done while not in REQ is ignored.
- WAIT_DIV:
  - Counter decrements each cycle; at 0 go to IDLE.
  - Dwell from render_done sample to the next possible render_req rise is STEP_DIV+1 cycles (1 of those is the IDLE decision cycle).
- Target changes mid-move:
  - No effect until the next IDLE decision; there is no abort of an in-flight request.
  - The direction is re-evaluated at every step, so a reversal or new target is honoured within one step.
- view_angle changes only on the IDLE→REQ transition; it is never modified in REQ or WAIT_DIV.
- Reset asserted mid-operation: immediate return to reset values; render_req drops asynchronously.

Optional Feature:
- Macro: RENDER_TIMEOUT_EN.
- Defined:
  - A 20-bit watchdog counts cycles in REQ.
  - If TIMEOUT cycles pass without render_done: render_req=0, render_err=1 (sticky until reset), go to WAIT_DIV. The step is treated as complete, and view_angle keeps its stepped value.
- Undefined:
  - No watchdog logic; REQ waits indefinitely.
  - render_err tied to 0.

Test Plan:
- Reset, then camera_offset=0 held 20 cycles → view_angle=0, render_req never asserts, busy=0.
- camera_offset=3, renderer answers done 2 cycles after each req, STEP_DIV=4:
  - view_angle goes 1,2,3 with step_dir=1.
  - Exactly 3 req pulses, each holding until done.
  - Then IDLE with busy=0.
- From view_angle=0, camera_offset=62 → view_angle goes 63 then 62, step_dir=0, 2 requests (wrap path, not 62 forward steps).
- From view_angle=0, camera_offset=32 → first step to 1 (tie → +1); change target to 0 while in REQ → next step goes back to 0, step_dir=0.
- render_done high in the same cycle render_req first rises, then held high constantly:
  - One step per req/done.
  - Gap between req rises equals STEP_DIV+2 cycles (REQ cycle, STEP_DIV dwell, IDLE decision).
- With RENDER_TIMEOUT_EN and TIMEOUT=16, render_done stuck 0:
  - render_req drops after 16 cycles in REQ and render_err=1.
  - Stepping continues; render_err stays 1 until rst_n pulse.
